// File: rtl/haze_pkg.sv
// haze_pkg: shared states, pass encodings and default geometry for the haze sequencer
package haze_pkg;
    typedef enum logic [2:0] {IDLE, ALE_PASS, ALE_WAIT, TE_PASS, DRAIN, DONE} state_t;
    localparam logic [1:0] PASS_IDLE = 2'd0;
    localparam logic [1:0] PASS_ALE  = 2'd1;
    localparam logic [1:0] PASS_TE   = 2'd2;
    localparam logic [1:0] PASS_DONE = 2'd3;
    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;
    localparam int DEF_CNT_W      = 18;
endpackage

// File: rtl/haze_pix_counter.sv
// haze_pix_counter: frame pixel counter with clear, increment and terminal flag
module haze_pix_counter
    import haze_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int N     = DEF_IMG_WIDTH * DEF_IMG_HEIGHT
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic clr,
    input  logic inc,
    output logic last
);
    logic [CNT_W-1:0] cnt;
    assign last = cnt == CNT_W'(N - 1);
    always_ff @(posedge ACLK)
        if (!ARESETn || clr) cnt <= '0;
        else if (inc) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/haze_pass_sequencer.sv
// haze_pass_sequencer: two-pass (ALE then TE/SRSC) frame controller owning all stream handshakes
module haze_pass_sequencer
    import haze_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       enable,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       ale_clear,
    output logic       ale_in_valid,
    input  logic       ale_done,
    output logic       te_in_valid,
    output logic       pipe_stall,
    input  logic       pipe_out_valid,
    input  logic       m_tready,
    output logic       m_tvalid,
    output logic       m_tlast,
    output logic [1:0] pass_id,
    output logic       err_tlast,
    output logic       o_intr
);
    localparam int N = IMG_WIDTH * IMG_HEIGHT;
    state_t state, state_nxt;
    logic start, in_beat, out_hs, in_last, out_last, out_act;
    assign start   = state == IDLE && enable;
    assign in_beat = s_tvalid && s_tready;
    assign out_hs  = m_tvalid && m_tready;
    haze_pix_counter #(.CNT_W(CNT_W), .N(N)) u_in_cnt (
        .ACLK(ACLK), .ARESETn(ARESETn), .clr(start), .inc(in_beat), .last(in_last)
    );
    haze_pix_counter #(.CNT_W(CNT_W), .N(N)) u_out_cnt (
        .ACLK(ACLK), .ARESETn(ARESETn), .clr(start), .inc(out_hs), .last(out_last)
    );
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            ale_clear <= 1'b0;
            o_intr    <= 1'b0;
            err_tlast <= 1'b0;
        end else begin
            state     <= state_nxt;
            ale_clear <= start;
            o_intr    <= state_nxt == DONE;
            err_tlast <= start ? 1'b0 : err_tlast || (in_beat && s_tlast && !in_last);
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable) state_nxt = ALE_PASS;
            ALE_PASS: if (in_beat && in_last) state_nxt = ALE_WAIT;
            ALE_WAIT: if (ale_done) state_nxt = TE_PASS;
            TE_PASS:  if (in_beat && in_last) state_nxt = DRAIN;
            DRAIN:    if (out_hs && out_last) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end
    // TE pass only takes input when the output side can move, so the pipeline never overfills
    always_comb begin
        out_act      = state == TE_PASS || state == DRAIN;
        s_tready     = state == ALE_PASS || (state == TE_PASS && m_tready);
        ale_in_valid = state == ALE_PASS && s_tvalid;
        te_in_valid  = state == TE_PASS && s_tvalid && m_tready;
        m_tvalid     = out_act && pipe_out_valid;
        pipe_stall   = out_act && !m_tready;
        m_tlast      = m_tvalid && out_last;
        pass_id      = state == IDLE ? PASS_IDLE :
                       (state == ALE_PASS || state == ALE_WAIT) ? PASS_ALE :
                       out_act ? PASS_TE : PASS_DONE;
    end
endmodule

// File: tb/tb_haze_pass_sequencer.sv
// tb_haze_pass_sequencer: directed bench with ALE/3-stage pipeline models and a TLAST scoreboard
module tb_haze_pass_sequencer;
    import haze_pkg::*;
    localparam int N = 16;
    logic ACLK = 0, ARESETn = 0, enable = 0, s_tvalid = 0, s_tlast = 0;
    logic ale_done = 0, pipe_out_valid = 0, m_tready = 1;
    logic s_tready, ale_clear, ale_in_valid, te_in_valid, pipe_stall, m_tvalid, m_tlast, err_tlast, o_intr;
    logic [1:0] pass_id;
    int checks = 0, errors = 0;
    int cyc = 0, n_ale, n_te, n_out, n_tlast, n_intr = 0, n_clr = 0, wait_cnt, ale_wait_cyc, total_out = 0;
    int last_out_cyc = 0, intr_cyc = 0, ale_delay = 5, bad_pix = -1;
    bit ale_hold = 0, toggle = 0, err_due = 0;
    logic [2:0] pipe;
    bit q[$];

    always #5 ACLK = ~ACLK;

    haze_pass_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .CNT_W(5)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .ale_clear(ale_clear), .ale_in_valid(ale_in_valid), .ale_done(ale_done),
        .te_in_valid(te_in_valid), .pipe_stall(pipe_stall), .pipe_out_valid(pipe_out_valid),
        .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .pass_id(pass_id),
        .err_tlast(err_tlast), .o_intr(o_intr)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        n_ale = 0; n_te = 0; n_out = 0; n_tlast = 0; wait_cnt = -1; ale_wait_cyc = 0;
        pipe = '0; err_due = 0; q.delete();
    endtask

    task automatic sample();
        if (ale_clear) begin
            n_clr++;
            model_clear();
            check("err_clr_at_start", err_tlast, 1'b0);
        end
        if (err_due) check("err_set", err_tlast, 1'b1);
        if (pass_id == PASS_ALE && n_ale < N) begin
            check("s_tready_ale", s_tready, 1'b1);
            check("ale_in_valid", ale_in_valid, s_tvalid);
        end
        if (pass_id == PASS_ALE && n_ale == N) begin
            check("s_tready_wait", s_tready, 1'b0);
            ale_wait_cyc++;
        end
        if (pass_id == PASS_TE) begin
            check("pipe_stall", pipe_stall, !m_tready);
            if (n_te < N) begin
                check("s_tready_te", s_tready, m_tready);
                check("te_in_valid", te_in_valid, s_tvalid && m_tready);
            end else check("s_tready_drain", s_tready, 1'b0);
        end else begin
            check("m_tvalid_off", m_tvalid, 1'b0);
            check("te_in_valid_off", te_in_valid, 1'b0);
        end
        if (pass_id == PASS_IDLE) check("s_tready_idle", s_tready, 1'b0);
        err_due = ale_in_valid && s_tlast && n_ale != N - 1;
        if (o_intr) begin n_intr++; intr_cyc = cyc; end
        if (ale_in_valid) begin
            n_ale++;
            if (n_ale == N) wait_cnt = 0;
        end
        if (te_in_valid) begin
            q.push_back(n_te == N - 1);
            n_te++;
        end
        if (m_tvalid && m_tready) begin
            n_out++; total_out++; last_out_cyc = cyc;
            if (m_tlast) n_tlast++;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=empty expected=entry");
            end
            if (q.size() != 0) check("m_tlast_sb", m_tlast, q.pop_front());
        end
        if (!pipe_stall) pipe = {pipe[1:0], te_in_valid};
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        cyc++;
        if (wait_cnt >= 0) wait_cnt++;
        ale_done       = ale_hold || (wait_cnt >= ale_delay);
        m_tready       = (toggle && pass_id == PASS_TE) ? cyc[0] : 1'b1;
        pipe_out_valid = pipe[2];
        s_tvalid       = 1'b1;
        s_tlast        = (pass_id == PASS_ALE && (n_ale == N - 1 || n_ale == bad_pix)) ||
                         (pass_id == PASS_TE && n_te == N - 1);
        #1;
        sample();
    endtask

    task automatic run_frame(string tag, int exp_wait, bit exp_err);
        int b;
        n_intr = 0; n_clr = 0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        b = 0;
        while (n_intr == 0 && b < 300) begin step(); b++; end
        check({tag, "_intr_seen"}, n_intr != 0, 1'b1);
        check({tag, "_ale_beats"}, n_ale, N);
        check({tag, "_te_beats"}, n_te, N);
        check({tag, "_outputs"}, n_out, N);
        check({tag, "_tlast_cnt"}, n_tlast, 1);
        check({tag, "_clr_cnt"}, n_clr, 1);
        check({tag, "_intr_lag"}, intr_cyc - last_out_cyc, 1);
        check({tag, "_wait_cyc"}, ale_wait_cyc, exp_wait);
        check({tag, "_pass_done"}, pass_id, PASS_DONE);
        check({tag, "_err_done"}, err_tlast, exp_err);
        step();
        check({tag, "_idle"}, pass_id, PASS_IDLE);
        check({tag, "_intr_pulse"}, o_intr, 1'b0);
        check({tag, "_err_idle"}, err_tlast, exp_err);
        check({tag, "_intr_once"}, n_intr, 1);
    endtask

    initial begin
        int b;
        model_clear();
        ARESETn = 1'b0;
        repeat (2) step();
        ARESETn = 1'b1;
        step();
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_pipe_stall", pipe_stall, 1'b0);
        check("rst_ale_clear", ale_clear, 1'b0);
        check("rst_o_intr", o_intr, 1'b0);
        check("rst_err", err_tlast, 1'b0);
        check("rst_pass", pass_id, PASS_IDLE);

        run_frame("basic", 5, 1'b0);
        toggle = 1; run_frame("toggle", 5, 1'b0); toggle = 0;
        ale_hold = 1; run_frame("hold", 1, 1'b0); ale_hold = 0;
        bad_pix = 7; run_frame("err", 5, 1'b1); bad_pix = -1;
        run_frame("after_err", 5, 1'b0);

        n_intr = 0;
        enable = 1'b1; step(); enable = 1'b0;
        b = 0;
        while (n_ale < 9 && b < 100) begin step(); b++; end
        ARESETn = 1'b0;
        step();
        ARESETn = 1'b1;
        check("mrst_s_tready", s_tready, 1'b0);
        check("mrst_m_tvalid", m_tvalid, 1'b0);
        check("mrst_pipe_stall", pipe_stall, 1'b0);
        check("mrst_ale_clear", ale_clear, 1'b0);
        check("mrst_err", err_tlast, 1'b0);
        check("mrst_pass", pass_id, PASS_IDLE);
        model_clear();
        repeat (20) step();
        check("mrst_no_intr", n_intr, 0);
        run_frame("post_rst", 5, 1'b0);

        n_intr = 0; n_clr = 0; total_out = 0;
        enable = 1'b1;
        b = 0;
        while (n_intr < 2 && b < 800) begin
            step(); b++;
            if (n_intr == 1 && n_clr == 2 && n_ale >= 8) enable = 1'b0;
        end
        check("b2b_intr", n_intr, 2);
        check("b2b_outputs", total_out, 2 * N);
        check("b2b_clr", n_clr, 2);
        check("b2b_enable_dropped", enable, 1'b0);
        repeat (10) step();
        check("b2b_idle", pass_id, PASS_IDLE);
        check("b2b_no_restart", n_clr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/haze_pass_sequencer.md
Name: haze_pass_sequencer

Overview:
- Frame-level controller for the haze-removal datapath. Each frame streams through the design twice.
- Pass 1 feeds every pixel to atmospheric-light estimation (ALE). The sequencer then waits for ALE to latch its result.
- Pass 2 feeds every pixel to transmission estimation and scene recovery (TE/SRSC). The sequencer counts outputs, generates M_AXIS TLAST and raises the frame-done interrupt.
- It owns every handshake/qualifier signal between the AXI4-Stream ports and the datapath. Pixel data bypasses it.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame.
- CNT_W, 18, pixel counter width; must satisfy 2^CNT_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, synchronous, active-low; clock ACLK.
- enable  in  1  start request; sampled only in IDLE.
- s_tvalid  in  1  S_AXIS_TVALID.
- s_tlast  in  1  S_AXIS_TLAST; checked only, never required.
- s_tready  out  1  S_AXIS_TREADY.
- ale_clear  out  1  one-cycle pulse that clears ALE accumulators at frame start.
- ale_in_valid  out  1  pixel qualifier into ALE.
- ale_done  in  1  ALE result (atmospheric light A) is valid.
- te_in_valid  out  1  pixel qualifier into TE/SRSC.
- pipe_stall  out  1  freezes TE/SRSC pipeline registers.
- pipe_out_valid  in  1  SRSC output valid (pipeline tail).
- m_tready  in  1  M_AXIS_TREADY.
- m_tvalid  out  1  M_AXIS_TVALID.
- m_tlast  out  1  M_AXIS_TLAST.
- pass_id  out  2  0 = idle, 1 = ALE pass, 2 = TE pass/drain, 3 = done.
- err_tlast  out  1  sticky: s_tlast seen on a non-final pixel.
- o_intr  out  1  frame-done pulse.

Behaviour:
- N = IMG_WIDTH*IMG_HEIGHT. Two counters: in_cnt counts accepted input beats; out_cnt counts output handshakes.
- State register and counters are registered. s_tready, ale_in_valid, te_in_valid, pipe_stall, m_tvalid and m_tlast are combinational from state, counters and inputs.
- Reset (ARESETn=0 at a rising edge) forces:
  - state IDLE, in_cnt=0, out_cnt=0;
  - ale_clear=0, o_intr=0, err_tlast=0.
  - Combinational outputs then evaluate to s_tready=0, m_tvalid=0, pipe_stall=0.
  - Reset mid-frame abandons the frame. No interrupt is raised.
- IDLE:
  - enable=1 -> ALE_PASS; registered ale_clear=1 for exactly one cycle; in_cnt, out_cnt and err_tlast cleared.
  - enable=0 -> stay in IDLE.
- ALE_PASS:
  - s_tready=1; ale_in_valid=s_tvalid; te_in_valid=0.
  - Each beat (s_tvalid&&s_tready) increments in_cnt.
  - Beat with in_cnt==N-1 -> in_cnt=0, go to ALE_WAIT.
- ALE_WAIT:
  - s_tready=0.
  - ale_done=1 -> TE_PASS.
  - If ale_done is already high on entry, TE_PASS is reached one cycle after the last ALE beat.
- TE_PASS:
  - s_tready=m_tready; te_in_valid=s_tvalid&&m_tready.
  - Beat with in_cnt==N-1 -> DRAIN.
- DRAIN:
  - s_tready=0.
  - Output handshake with out_cnt==N-1 -> DONE.
- Output side, valid in TE_PASS and DRAIN (0 in all other states):
  - m_tvalid=pipe_out_valid.
  - pipe_stall=~m_tready.
  - m_tlast=m_tvalid&&(out_cnt==N-1).
  - Handshake (m_tvalid&&m_tready) increments out_cnt.
  - An output handshake and an input beat in the same cycle update both counters independently.
- DONE:
  - o_intr=1 for exactly one cycle, then IDLE.
  - Frames run back-to-back if enable is still high.
- enable deasserted mid-frame has no effect; the frame completes.
- err_tlast:
  - Set on any input beat with s_tlast=1 and in_cnt!=N-1, in either pass.
  - Stays set until the next frame start or reset.
  - A missing TLAST on the final pixel is not an error.
- Input beats presented outside ALE_PASS/TE_PASS are not accepted (s_tready=0) and do not change any counter.
- pass_id: IDLE=0, ALE_PASS/ALE_WAIT=1, TE_PASS/DRAIN=2, DONE=3.

Decomposition:
- Shared package haze_pkg holds:
  - state enum (IDLE, ALE_PASS, ALE_WAIT, TE_PASS, DRAIN, DONE);
  - pass_id encodings;
  - default IMG_WIDTH/IMG_HEIGHT/CNT_W.
- One natural sub-module: haze_pix_counter, a CNT_W-bit counter with clear, increment and terminal flag (count==N-1). Instantiated twice, for in_cnt and out_cnt.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 (N=16). The bench models ALE and a 3-cycle TE/SRSC pipeline.
- Full frame, continuous valid, m_tready=1, ale_done 5 cycles after the last ALE beat:
  - exactly 16 ale_in_valid and 16 te_in_valid beats;
  - 16 m_tvalid beats, m_tlast only on the 16th;
  - one o_intr pulse one cycle after the last output; back in IDLE.
- m_tready toggled 1-0-1 every cycle in TE_PASS:
  - s_tready and te_in_valid follow m_tready; pipe_stall=~m_tready;
  - output count is still 16 with exactly one m_tlast.
- ale_done held high throughout: TE_PASS is entered the cycle after the 16th ALE beat; no extra wait cycles.
- s_tlast=1 on pixel 7 of the ALE pass:
  - err_tlast=1 from the next cycle, held through DONE;
  - cleared at the next frame start; pixel counts are unaffected.
- ARESETn low for one cycle at ALE-pass pixel 9:
  - all outputs return to reset values; no o_intr;
  - a following enable runs a clean 16+16-pixel frame with ale_clear pulsed once.
- enable held high: two frames run back-to-back, giving two o_intr pulses and 32 total outputs; enable dropped mid-frame 2 still completes it.
